// File: rtl/rbcp_reg_responder_if.sv
// rbcp_reg_responder_if: SiTCP RBCP slow-control bus (single-byte read/write with one-cycle ACK)
interface rbcp_reg_responder_if;
  logic [31:0] RBCP_ADDR;
  logic [7:0] RBCP_WD;
  logic RBCP_WE;
  logic RBCP_RE;
  logic RBCP_ACK;
  logic [7:0] RBCP_RD;
  modport master (output RBCP_ADDR, RBCP_WD, RBCP_WE, RBCP_RE, input RBCP_ACK, RBCP_RD);
  modport slave (input RBCP_ADDR, RBCP_WD, RBCP_WE, RBCP_RE, output RBCP_ACK, RBCP_RD);
endinterface

// File: rtl/rbcp_reg_responder.sv
// rbcp_reg_responder: RBCP register-file responder; define RBCP_SNAPSHOT_EN for coherent STATUS_IN reads
module rbcp_reg_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [7:0] ID_CODE = 8'hA5
) (
  input logic CLK,
  input logic SYS_RSTn,
  rbcp_reg_responder_if.slave rbcp,
  input logic [31:0] STATUS_IN,
  output logic [63:0] CTRL_OUT,
  output logic [7:0] PULSE_OUT
);
  typedef enum logic [1:0] {IDLE, EXEC, ACK} state_t;
  state_t state_q, state_d;
  logic [4:0] off_q, off_d;
  logic [7:0] wd_q, wd_d, pulse_q, pulse_d, err_q, err_d, data_q, data_d, rd_q, rd_d, rdata;
  logic wr_q, wr_d, ack_q, ack_d;
  logic [63:0] ctrl_q, ctrl_d;
  logic [31:0] status;
  logic hit, is_status;
  assign hit = rbcp.RBCP_ADDR[31:5] == BASE_ADDR[31:5];
  assign is_status = off_q[4:2] == 3'b011;
`ifdef RBCP_SNAPSHOT_EN
  logic [31:0] snap_q, snap_d;
  // 0x0C reads live and refreshes the snapshot; 0x0D-0x0F read the frozen copy
  assign status = off_q == 5'h0C ? STATUS_IN : snap_q;
  assign snap_d = state_q == EXEC && !wr_q && off_q == 5'h0C ? STATUS_IN : snap_q;
  always_ff @(posedge CLK) snap_q <= SYS_RSTn ? snap_d : '0;
`else
  assign status = STATUS_IN;
`endif
  assign rdata = off_q[4:3] == 2'b00 ? ctrl_q[{off_q[2:0], 3'b000} +: 8] :
                 off_q == 5'h09 ? ID_CODE :
                 is_status ? status[{~off_q[1:0], 3'b000} +: 8] :
                 off_q == 5'h10 ? err_q : 8'h00;
  always_comb begin
    state_d = state_q;
    off_d = off_q;
    wd_d = wd_q;
    wr_d = wr_q;
    ctrl_d = ctrl_q;
    err_d = err_q;
    data_d = data_q;
    pulse_d = '0;
    ack_d = 1'b0;
    rd_d = '0;
    case (state_q)
      IDLE: if ((rbcp.RBCP_WE || rbcp.RBCP_RE) && hit) begin
        state_d = EXEC;
        off_d = rbcp.RBCP_ADDR[4:0];
        wd_d = rbcp.RBCP_WD;
        wr_d = rbcp.RBCP_WE;
      end
      EXEC: begin
        state_d = ACK;
        data_d = wr_q ? 8'h00 : rdata;
        if (wr_q) begin
          if (off_q[4:3] == 2'b00) ctrl_d[{off_q[2:0], 3'b000} +: 8] = wd_q;
          if (off_q == 5'h08) pulse_d = wd_q;
          if (off_q == 5'h10) err_d = '0;
          else if ((off_q == 5'h09 || is_status) && err_q != 8'hFF) err_d = err_q + 8'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
        ack_d = 1'b1;
        rd_d = data_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!SYS_RSTn) begin
      state_q <= IDLE;
      off_q <= '0;
      wd_q <= '0;
      wr_q <= 1'b0;
      ctrl_q <= '0;
      err_q <= '0;
      data_q <= '0;
      pulse_q <= '0;
      ack_q <= 1'b0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      off_q <= off_d;
      wd_q <= wd_d;
      wr_q <= wr_d;
      ctrl_q <= ctrl_d;
      err_q <= err_d;
      data_q <= data_d;
      pulse_q <= pulse_d;
      ack_q <= ack_d;
      rd_q <= rd_d;
    end
  end
  assign rbcp.RBCP_ACK = ack_q;
  assign rbcp.RBCP_RD = rd_q;
  assign CTRL_OUT = ctrl_q;
  assign PULSE_OUT = pulse_q;
endmodule
